// File: rtl/issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : issue_ctrl_if
// Description : Decode, writeback, branch-resolve and trap signals between
//               the issue controller and the surrounding pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
interface issue_ctrl_if;

    // Registered decode outputs
    logic        in_valid;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  opcode;
    logic [31:0] pc;
    logic        load;
    logic        fence;
    logic        alui;
    logic        auipc;
    logic        store;
    logic        alur;
    logic        lui;
    logic        branch;
    logic        jalr;
    logic        jal;
    logic        system;
    logic        invalid;

    // Writeback, execute resolution and trap handler
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        br_done;
    logic        br_taken;
    logic        trap_ack;

    // Controller outputs
    logic        issue;
    logic        hlt;
    logic        flush;
    logic        trap;
    logic [31:0] trap_pc;
    logic [1:0]  trap_cause;
    logic [31:0] busy;
    logic        idle;

    modport master (
        output in_valid, rd, rs1, rs2, opcode, pc,
        output load, fence, alui, auipc, store, alur, lui,
        output branch, jalr, jal, system, invalid,
        output wb_valid, wb_rd, br_done, br_taken, trap_ack,
        input  issue, hlt, flush, trap, trap_pc, trap_cause, busy, idle
    );

    modport slave (
        input  in_valid, rd, rs1, rs2, opcode, pc,
        input  load, fence, alui, auipc, store, alur, lui,
        input  branch, jalr, jal, system, invalid,
        input  wb_valid, wb_rd, br_done, br_taken, trap_ack,
        output issue, hlt, flush, trap, trap_pc, trap_cause, busy, idle
    );

endinterface
`default_nettype wire

// File: rtl/issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : issue_ctrl
// Description : Issue/hazard controller: register scoreboard, decode stall,
//               control-transfer resolve/flush sequencing and trap handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module issue_ctrl #(
    parameter int RESOLVE_MAX = 15
) (
    input  wire logic     clk,
    input  wire logic     rstn,
    issue_ctrl_if.slave   bus
);

    localparam logic [1:0] c_st_run     = 2'd0;
    localparam logic [1:0] c_st_resolve = 2'd1;
    localparam logic [1:0] c_st_flush   = 2'd2;
    localparam logic [1:0] c_st_trap    = 2'd3;

    localparam logic [1:0] c_cause_invalid = 2'd0;
    localparam logic [1:0] c_cause_timeout = 2'd1;

    localparam logic [7:0] c_resolve_max = 8'(RESOLVE_MAX);

    logic [1:0]  state_q,      state_d;
    logic [31:0] busy_q,       busy_d;
    logic [7:0]  cnt_q,        cnt_d;
    logic        trap_q,       trap_d;
    logic [31:0] trap_pc_q,    trap_pc_d;
    logic [1:0]  trap_cause_q, trap_cause_d;
    logic [31:0] br_pc_q,      br_pc_d;

    logic        w_uses_rs1;
    logic        w_uses_rs2;
    logic        w_writes_rd;
    logic        w_xfer;
    logic [31:0] w_wb_clr;
    logic [31:0] w_eff_busy;
    logic [31:0] w_set;
    logic        w_hazard;
    logic        w_issue;
    logic        w_hlt;
    logic [7:0]  w_cnt_inc;
    logic        w_unused;

    // Opcode and the load/alui flags do not change register usage here.
    assign w_unused = &{1'b0, bus.opcode, bus.load, bus.alui};

    // Register usage and hazard detection against the bypassed scoreboard
    always_comb begin
        w_uses_rs1  = !(bus.lui || bus.auipc || bus.jal || bus.fence);
        w_uses_rs2  = bus.store || bus.alur || bus.branch;
        w_writes_rd = !(bus.store || bus.branch || bus.fence) && (bus.rd != 5'd0);
        w_xfer      = bus.branch || bus.jal || bus.jalr;

        w_wb_clr = 32'd0;
        if (bus.wb_valid && (bus.wb_rd != 5'd0)) begin
            w_wb_clr = 32'd1 << bus.wb_rd;
        end
        w_eff_busy = busy_q & ~w_wb_clr;

        w_hazard = (w_uses_rs1 && w_eff_busy[bus.rs1])
                || (w_uses_rs2 && w_eff_busy[bus.rs2])
                || (w_writes_rd && w_eff_busy[bus.rd])
                || ((bus.fence || bus.system) && (busy_q != 32'd0));
    end

    // Issue/stall decode and next-state sequencing
    always_comb begin
        w_issue      = 1'b0;
        w_hlt        = 1'b1;
        state_d      = state_q;
        cnt_d        = cnt_q;
        trap_d       = trap_q;
        trap_pc_d    = trap_pc_q;
        trap_cause_d = trap_cause_q;
        br_pc_d      = br_pc_q;
        w_cnt_inc    = cnt_q + 8'd1;

        case (state_q)
            c_st_run: begin
                w_issue = bus.in_valid && !bus.invalid && !w_hazard;
                w_hlt   = bus.in_valid && (bus.invalid || w_hazard);
                if (bus.in_valid && bus.invalid) begin
                    state_d      = c_st_trap;
                    trap_d       = 1'b1;
                    trap_pc_d    = bus.pc;
                    trap_cause_d = c_cause_invalid;
                end else if (w_issue && w_xfer) begin
                    state_d = c_st_resolve;
                    cnt_d   = 8'd0;
                    br_pc_d = bus.pc;
                end
            end

            c_st_resolve: begin
                // Resolution in the timeout cycle wins over the timeout.
                if (bus.br_done) begin
                    state_d = bus.br_taken ? c_st_flush : c_st_run;
                end else begin
                    cnt_d = w_cnt_inc;
                    if (w_cnt_inc == c_resolve_max) begin
                        state_d      = c_st_trap;
                        trap_d       = 1'b1;
                        trap_pc_d    = br_pc_q;
                        trap_cause_d = c_cause_timeout;
                    end
                end
            end

            c_st_flush: begin
                state_d = c_st_run;
            end

            c_st_trap: begin
                if (bus.trap_ack) begin
                    state_d = c_st_flush;
                    trap_d  = 1'b0;
                end
            end

            default: begin
                state_d = c_st_run;
            end
        endcase
    end

    // Scoreboard: retire writebacks, then mark the issuing destination
    always_comb begin
        w_set = 32'd0;
        if (w_issue && w_writes_rd) begin
            w_set = 32'd1 << bus.rd;
        end
        busy_d    = (busy_q & ~w_wb_clr) | w_set;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= c_st_run;
            busy_q       <= 32'd0;
            cnt_q        <= 8'd0;
            trap_q       <= 1'b0;
            trap_pc_q    <= 32'd0;
            trap_cause_q <= 2'd0;
            br_pc_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
            trap_q       <= trap_d;
            trap_pc_q    <= trap_pc_d;
            trap_cause_q <= trap_cause_d;
            br_pc_q      <= br_pc_d;
        end
    end

    assign bus.issue      = w_issue;
    assign bus.hlt        = w_hlt;
    assign bus.flush      = (state_q == c_st_flush);
    assign bus.trap       = trap_q;
    assign bus.trap_pc    = trap_pc_q;
    assign bus.trap_cause = trap_cause_q;
    assign bus.busy       = busy_q;
    assign bus.idle       = (busy_q == 32'd0) && (state_q == c_st_run);

endmodule
`default_nettype wire

// File: doc/issue_ctrl.md
# issue_ctrl

Issue/hazard controller between the decode stage and execute. It watches the registered decode outputs and holds a register scoreboard of pending writebacks. It generates the decode/fetch `hlt` stall and a one-cycle `flush` after taken control transfers or traps, and it serialises fence/system instructions. It also converts invalid or unknown opcodes and stuck branch resolution into a trap handshake.

## Interface
Parameters:
- RESOLVE_MAX, 15: maximum cycles spent in RESOLVE before a timeout trap; range 1..255.

Ports (reset `rstn`, synchronous, active-low; clock `clk`):
- clk  in  1  clock; all state changes on the rising edge.
- rstn  in  1  synchronous active-low reset.
- in_valid  in  1  decode outputs hold a real instruction.
- rd, rs1, rs2  in  5 each  register fields from decode.
- opcode  in  7  opcode from decode.
- pc  in  32  outpc from decode.
- load, fence, alui, auipc, store, alur, lui, branch, jalr, jal, system  in  1 each  one-hot class flags.
- invalid  in  1  decode fault flag; covers unknown.
- wb_valid  in  1  writeback retires a register write this cycle.
- wb_rd  in  5  register being written back.
- br_done  in  1  execute has resolved the outstanding control transfer.
- br_taken  in  1  the transfer redirected the PC; sampled with br_done.
- trap_ack  in  1  trap handler has accepted the trap.
- issue  out  1  instruction accepted into execute this cycle; combinational.
- hlt  out  1  stall fetch/decode; combinational.
- flush  out  1  squash fetch/decode contents; registered state decode.
- trap  out  1  trap pending; registered.
- trap_pc  out  32  pc of the trapping instruction.
- trap_cause  out  2  0 = invalid, 1 = resolve timeout, others reserved.
- busy  out  32  scoreboard; bit 0 is always 0.
- idle  out  1  busy == 0 and state == RUN.

## Operation
- Register use:
  - uses_rs1 = !(lui|auipc|jal|fence).
  - uses_rs2 = store|alur|branch.
  - writes_rd = !(store|branch|fence) && rd != 0.
- Effective busy for a hazard check: busy[r] && !(wb_valid && wb_rd == r); writeback bypasses in the same cycle.
- Hazard when any of:
  - uses_rs1 and rs1 is busy.
  - uses_rs2 and rs2 is busy.
  - writes_rd and rd is busy (WAW).
  - fence or system while busy != 0.
- States:
  - RUN: normal issue.
  - RESOLVE: waiting for br_done.
  - FLUSH: one-cycle squash.
  - TRAP: waiting for trap_ack.
- RUN:
  - issue = in_valid && !invalid && !hazard.
  - hlt = in_valid && (invalid || hazard).
  - Issue of branch/jal/jalr → RESOLVE; the resolve counter clears to 0.
  - in_valid && invalid → TRAP. Set trap=1, trap_pc=pc, trap_cause=0. No issue.
- RESOLVE:
  - hlt=1 and issue=0.
  - br_done && br_taken → FLUSH.
  - br_done && !br_taken → RUN.
  - Otherwise the counter increments. When the counter reaches RESOLVE_MAX: go to TRAP with trap_cause=1 and trap_pc = pc of the branch, latched at issue.
- FLUSH: flush=1, hlt=1, issue=0 for exactly one cycle, then RUN.
- TRAP:
  - hlt=1 and trap=1.
  - trap_ack → FLUSH; trap clears on the same edge.
  - br_done is ignored while in TRAP.
- Scoreboard:
  - Issue with writes_rd sets busy[rd].
  - wb_valid clears busy[wb_rd].
  - Set and clear of the same bit on the same edge: set wins.
  - wb_rd == 0 or a clear of a non-busy bit has no effect.
  - Writebacks keep draining in every state.

## Timing
- Reset values: state=RUN, busy=0, trap=0, trap_pc=0, trap_cause=0, flush=0, counter=0. With in_valid=0: issue=0, hlt=0, idle=1.
- Reset mid-RESOLVE or mid-TRAP: the next cycle is RUN with an empty scoreboard. Pending writebacks after reset are ignored; bits are already 0.
- issue/hlt are combinational from registered state and decode outputs. Decode holds while hlt=1, so a stalled instruction re-presents unchanged.
- Taken-branch penalty: issue cycle, ≥1 RESOLVE cycle, 1 FLUSH cycle.
- Load-use: consumer stalls until the cycle wb_valid retires its source. It issues in that same cycle via the bypass.
- RESOLVE timeout: TRAP is entered on the edge where the counter equals RESOLVE_MAX. br_done in that same cycle takes priority over the timeout.

## Test plan
- Reset with rstn=0 for 2 cycles → busy=0, trap=0, flush=0, idle=1, hlt=0.
- Stall and bypass:
  - Stimulus: load x5, then alur with rs1=5; wb_valid=1, wb_rd=5 arrives 3 cycles later.
  - Required: 3 cycles of hlt=1; alur issues in the wb cycle; busy[5] stays 1 because the alur rd=5 set wins.
- Branch:
  - Stimulus: branch issue, br_done=1, br_taken=1 two cycles later.
  - Required: RESOLVE ×2, FLUSH ×1 with flush=1, back to RUN.
  - Repeat with br_taken=0 → no flush.
- Fence: fence with busy={x3,x7} → hlt until both clear, then issue=1.
- Invalid: invalid=1, pc=0x100 → trap=1, trap_pc=0x100, trap_cause=0; held until trap_ack, then 1 flush cycle.
- Timeout: jal issued, br_done never asserted, RESOLVE_MAX=4 → trap_cause=1 after 4 RESOLVE cycles.
- Reset mid-operation: rstn=0 during TRAP → trap=0, RUN next cycle.
